// File: rtl/fifo_stream_reader_pkg.sv
// Shared width helpers for the FIFO read-side width adapters.
// Use these helpers so that every adapter derives its slice count and
// slice index width the same way.
package fifo_stream_reader_pkg;

  // Returns ceil(log2(value)). Returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Returns the number of narrow beats per wide word.
  // A zero OUT_WIDTH is caught by the width check in the adapter, so here it
  // maps to 1 only to keep elaboration going until that check reports it.
  function automatic int unsigned calc_num_slices(input int unsigned data_width,
                                                  input int unsigned out_width);
    return (out_width == 0) ? 1 : data_width / out_width;
  endfunction

  // Returns the slice index width. It is at least 1 bit, so that a
  // single-slice adapter still has a legal index.
  function automatic int unsigned calc_slice_w(input int unsigned num_slices);
    return (num_slices <= 1) ? 1 : clog2(num_slices);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buffer2.sv
// Two-entry circular register buffer used as a skid stage behind a
// registered-read FIFO. The owner guarantees that push never lands on a
// full buffer and that pop never hits an empty one.
module skid_buffer2 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_idx_q;
  logic             rd_idx_q;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;

  // Occupancy moves by +push -pop. When both happen together it is unchanged.
  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!push && pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  // Storage and pointers. Reset discards every buffered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_idx_q] <= push_data;
        wr_idx_q        <= ~wr_idx_q;
      end
      if (pop) begin
        rd_idx_q <= ~rd_idx_q;
      end
      occ_q <= occ_d;
    end
  end

  assign head_data = mem_q[rd_idx_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the synchronous FIFO. It pops words, parks them in
// a 2-entry skid buffer and streams each word as NUM_SLICES narrow beats,
// LSB slice first, on a valid/ready interface at one beat per cycle.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_pop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int unsigned NUM_SLICES = calc_num_slices(DATA_WIDTH, OUT_WIDTH);
  localparam int unsigned SLICE_W    = calc_slice_w(NUM_SLICES);

  if (OUT_WIDTH == 0 || (DATA_WIDTH % OUT_WIDTH) != 0) begin : g_width_check
    $error("fifo_stream_reader: OUT_WIDTH must divide DATA_WIDTH exactly");
  end

  logic                  inflight_q;
  logic [SLICE_W-1:0]    slice_q;
  logic [SLICE_W-1:0]    slice_d;
  logic [1:0]            occupancy;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  last_slice;
  logic                  fire;
  logic                  deq;
  logic [2:0]            credit_sum;

  // The skid buffer captures a word one cycle after its pop (registered FIFO
  // read). It releases the word once the final slice of that word is accepted.
  skid_buffer2 #(
    .WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (fifo_data_out),
    .pop       (deq),
    .head_data (head_data),
    .occupancy (occupancy)
  );

  // Beat handshake, dequeue and pop credit.
  always_comb begin
    last_slice = (slice_q == SLICE_W'(NUM_SLICES - 1));
    m_valid    = (occupancy != 2'd0);
    fire       = m_valid & m_ready;
    deq        = fire & last_slice;
    // Words held or in flight after this edge. deq implies occupancy >= 1,
    // so the subtraction cannot wrap.
    credit_sum = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, deq};
    // Combinational pop. A word can leave and a new one be requested in the
    // same cycle, which keeps full rate.
    fifo_pop   = !reset & !fifo_empty & (credit_sum < 3'd2);
    m_last     = m_valid & last_slice;
    m_data     = head_data[int'(slice_q) * OUT_WIDTH +: OUT_WIDTH];
    busy       = (occupancy != 2'd0) | inflight_q;
  end

  // Slice index: step on every accepted beat, and wrap after the last slice.
  always_comb begin
    slice_d = slice_q;
    if (fire) begin
      slice_d = last_slice ? '0 : slice_q + 1'b1;
    end
  end

  // In-flight flag and slice index. Reset drops any outstanding pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      slice_q    <= '0;
    end else begin
      inflight_q <= fifo_pop;
      slice_q    <= slice_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader.
// It models a registered-read FIFO in front of two DUTs: a 64->16 instance
// with four slices and a 64->64 instance with one slice.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic        empty4 = 1'b1;
  logic [63:0] dout4;
  logic        pop4;
  logic        mv4;
  logic        mr4 = 1'b0;
  logic [15:0] md4;
  logic        ml4;
  logic        busy4;

  logic        empty1 = 1'b1;
  logic [63:0] dout1;
  logic        pop1;
  logic        mv1;
  logic        mr1 = 1'b0;
  logic [63:0] md1;
  logic        ml1;
  logic        busy1;

  fifo_stream_reader #(.DATA_WIDTH(64), .OUT_WIDTH(16)) dut4 (
    .clk(clk), .reset(reset), .fifo_empty(empty4), .fifo_data_out(dout4),
    .fifo_pop(pop4), .m_valid(mv4), .m_ready(mr4), .m_data(md4), .m_last(ml4),
    .busy(busy4)
  );

  fifo_stream_reader #(.DATA_WIDTH(64), .OUT_WIDTH(64)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(empty1), .fifo_data_out(dout1),
    .fifo_pop(pop1), .m_valid(mv1), .m_ready(mr1), .m_data(md1), .m_last(ml1),
    .busy(busy1)
  );

  logic [63:0] fq4[$];
  logic [63:0] fq1[$];
  logic [16:0] exp4[$];
  logic [64:0] exp1[$];
  int total = 0;
  int bad   = 0;
  int pops4 = 0;
  int pops1 = 0;

  // FIFO models. Read data is registered, and the FIFO shares the reset.
  always @(posedge clk) begin
    if (reset) begin
      fq4.delete();
    end else if (pop4) begin
      pops4++;
      total++;
      if (fq4.size() == 0) begin
        bad++;
        $display("FAIL pop4_on_empty: pop=1 with empty FIFO, want no pop");
      end else begin
        dout4 <= fq4.pop_front();
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      fq1.delete();
    end else if (pop1) begin
      pops1++;
      total++;
      if (fq1.size() == 0) begin
        bad++;
        $display("FAIL pop1_on_empty: pop=1 with empty FIFO, want no pop");
      end else begin
        dout1 <= fq1.pop_front();
      end
    end
  end

  // Occupancy invariants, sampled before each edge.
  always @(posedge clk) begin
    if (!reset) begin
      total++;
      if (dut4.occupancy > 2'd2 ||
          int'(dut4.inflight_q) + int'(dut4.occupancy) > 2 + int'(dut4.deq)) begin
        bad++;
        $display("FAIL occ_inv4: occ=%0d inflight=%0d deq=%0d, want occ<=2 and inf+occ<=2+deq",
                 dut4.occupancy, dut4.inflight_q, dut4.deq);
      end
      total++;
      if (dut1.occupancy > 2'd2 ||
          int'(dut1.inflight_q) + int'(dut1.occupancy) > 2 + int'(dut1.deq)) begin
        bad++;
        $display("FAIL occ_inv1: occ=%0d inflight=%0d deq=%0d, want occ<=2 and inf+occ<=2+deq",
                 dut1.occupancy, dut1.inflight_q, dut1.deq);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    empty4 = (fq4.size() == 0);
    empty1 = (fq1.size() == 0);
  endtask

  task automatic push4(input logic [63:0] w);
    fq4.push_back(w);
    for (int s = 0; s < 4; s++) begin
      exp4.push_back({(s == 3) ? 1'b1 : 1'b0, w[s*16 +: 16]});
    end
    empty4 = 1'b0;
  endtask

  task automatic push1(input logic [63:0] w);
    fq1.push_back(w);
    exp1.push_back({1'b1, w});
    empty1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mr4 = 1'b0;
    mr1 = 1'b0;
    repeat (3) tick();
    #1;
    total++; if (mv4 !== 1'b0) begin bad++; $display("FAIL reset_valid4: got %b want 0", mv4); end
    total++; if (ml4 !== 1'b0) begin bad++; $display("FAIL reset_last4: got %b want 0", ml4); end
    total++; if (pop4 !== 1'b0) begin bad++; $display("FAIL reset_pop4: got %b want 0", pop4); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy4: got %b want 0", busy4); end
    total++; if (md4 !== 16'h0) begin bad++; $display("FAIL reset_data4: got %h want 0", md4); end
    total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL reset_valid1: got %b want 0", mv1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    int p0 = pops4;
    int first = -1;
    int lastc = -1;
    int beats = 0;
    logic [16:0] e;
    push4(64'h4444_3333_2222_1111);
    mr4 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mv4 && mr4) begin
        total++;
        if (exp4.size() == 0) begin
          bad++; $display("FAIL single_extra_beat: got data=%h, want no beat", md4);
        end else begin
          e = exp4.pop_front();
          if ({ml4, md4} !== e) begin
            bad++; $display("FAIL single_beat: got last=%b data=%h want last=%b data=%h",
                            ml4, md4, e[16], e[15:0]);
          end
        end
        if (first < 0) first = c;
        lastc = c;
        beats++;
      end
      tick();
    end
    #1;
    total++; if (first !== 2) begin bad++; $display("FAIL single_latency: got %0d want 2", first); end
    total++; if (beats !== 4) begin bad++; $display("FAIL single_beats: got %0d want 4", beats); end
    total++; if (lastc - first !== 3) begin bad++; $display("FAIL single_contig: got span %0d want 3", lastc - first); end
    total++; if (pops4 - p0 !== 1) begin bad++; $display("FAIL single_pops: got %0d want 1", pops4 - p0); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy4); end
  endtask

  task automatic test_full_rate();
    int p0 = pops1;
    int firstpop = -1;
    int first = -1;
    int lastc = -1;
    int beats = 0;
    logic [64:0] e;
    for (int i = 0; i < 8; i++) push1(64'(i));
    mr1 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (pop1 && firstpop < 0) firstpop = c;
      if (mv1 && mr1) begin
        total++;
        if (exp1.size() == 0) begin
          bad++; $display("FAIL rate_extra_beat: got data=%h, want no beat", md1);
        end else begin
          e = exp1.pop_front();
          if ({ml1, md1} !== e) begin
            bad++; $display("FAIL rate_beat: got last=%b data=%h want last=%b data=%h",
                            ml1, md1, e[64], e[63:0]);
          end
        end
        if (first < 0) first = c;
        lastc = c;
        beats++;
      end
      tick();
    end
    mr1 = 1'b0;
    total++; if (first - firstpop !== 2) begin bad++; $display("FAIL rate_latency: got %0d want 2", first - firstpop); end
    total++; if (beats !== 8) begin bad++; $display("FAIL rate_beats: got %0d want 8", beats); end
    total++; if (lastc - first !== 7) begin bad++; $display("FAIL rate_bubbles: got span %0d want 7", lastc - first); end
    total++; if (pops1 - p0 !== 8) begin bad++; $display("FAIL rate_pops: got %0d want 8", pops1 - p0); end
  endtask

  task automatic test_backpressure();
    int p0 = pops4;
    int beats = 0;
    logic seen = 1'b0;
    logic stable = 1'b1;
    logic [15:0] held = '0;
    logic [16:0] e;
    mr4 = 1'b0;
    push4(64'hA003_A002_A001_A000);
    push4(64'hB003_B002_B001_B000);
    push4(64'hC003_C002_C001_C000);
    push4(64'hD003_D002_D001_D000);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mv4) begin
        if (!seen) begin
          held = md4;
          seen = 1'b1;
        end else if (md4 !== held) begin
          stable = 1'b0;
        end
      end
      tick();
    end
    #1;
    total++; if (pops4 - p0 !== 2) begin bad++; $display("FAIL bp_pops: got %0d want 2", pops4 - p0); end
    total++; if (dut4.occupancy !== 2'd2) begin bad++; $display("FAIL bp_occ: got %0d want 2", dut4.occupancy); end
    total++; if (mv4 !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", mv4); end
    total++; if (stable !== 1'b1 || held !== 16'hA000) begin
      bad++; $display("FAIL bp_stable: got stable=%b held=%h want 1 and a000", stable, held);
    end
    for (int c = 0; c < 60 && exp4.size() > 0; c++) begin
      mr4 = 1'b1;
      #1;
      if (mv4 && mr4) begin
        e = exp4.pop_front();
        total++;
        if ({ml4, md4} !== e) begin
          bad++; $display("FAIL bp_beat: got last=%b data=%h want last=%b data=%h",
                          ml4, md4, e[16], e[15:0]);
        end
        beats++;
      end
      tick();
    end
    total++; if (exp4.size() !== 0) begin bad++; $display("FAIL bp_drain: got %0d left want 0", exp4.size()); end
    total++; if (beats !== 16) begin bad++; $display("FAIL bp_beats: got %0d want 16", beats); end
    repeat (3) tick();
  endtask

  task automatic test_empty();
    logic anypop = 1'b0;
    logic anyvalid = 1'b0;
    mr4 = 1'b1;
    mr1 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (pop4 || pop1) anypop = 1'b1;
      if (mv4 || mv1) anyvalid = 1'b1;
      tick();
    end
    total++; if (anypop !== 1'b0) begin bad++; $display("FAIL empty_pop: got 1 want 0"); end
    total++; if (anyvalid !== 1'b0) begin bad++; $display("FAIL empty_valid: got 1 want 0"); end
    mr1 = 1'b0;
  endtask

  task automatic test_random();
    int beats = 0;
    logic [16:0] e;
    for (int i = 0; i < 100; i++) push4({$urandom, $urandom});
    for (int c = 0; c < 3000 && exp4.size() > 0; c++) begin
      mr4 = 1'($urandom_range(0, 1));
      #1;
      if (mv4 && mr4) begin
        e = exp4.pop_front();
        total++;
        if ({ml4, md4} !== e) begin
          bad++; $display("FAIL rand_beat %0d: got last=%b data=%h want last=%b data=%h",
                          beats, ml4, md4, e[16], e[15:0]);
        end
        beats++;
      end
      tick();
    end
    total++; if (exp4.size() !== 0) begin bad++; $display("FAIL rand_timeout: got %0d left want 0", exp4.size()); end
    total++; if (beats !== 400) begin bad++; $display("FAIL rand_beats: got %0d want 400", beats); end
    mr4 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    logic [16:0] e;
    mr4 = 1'b0;
    push4(64'h1111_1111_1111_1111);
    push4(64'h2222_2222_2222_2222);
    push4(64'h3333_3333_3333_3333);
    tick();
    tick();
    #1;
    total++; if (dut4.occupancy !== 2'd1 || dut4.inflight_q !== 1'b1) begin
      bad++; $display("FAIL mid_pre: got occ=%0d inflight=%b want 1 and 1", dut4.occupancy, dut4.inflight_q);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (mv4 !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", mv4); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy4); end
    total++; if (dut4.slice_q !== 2'd0) begin bad++; $display("FAIL mid_slice: got %0d want 0", dut4.slice_q); end
    total++; if (fq4.size() !== 0) begin bad++; $display("FAIL mid_fifo_flush: got %0d want 0", fq4.size()); end
    exp4.delete();
    push4(64'h0DD3_0DD2_0DD1_0DD0);
    push4(64'h0EE3_0EE2_0EE1_0EE0);
    mr4 = 1'b1;
    for (int c = 0; c < 40 && exp4.size() > 0; c++) begin
      #1;
      if (mv4 && mr4) begin
        e = exp4.pop_front();
        total++;
        if ({ml4, md4} !== e) begin
          bad++; $display("FAIL mid_beat: got last=%b data=%h want last=%b data=%h",
                          ml4, md4, e[16], e[15:0]);
        end
        beats++;
      end
      tick();
    end
    total++; if (beats !== 8) begin bad++; $display("FAIL mid_beats: got %0d want 8", beats); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_rate();
    test_backpressure();
    test_empty();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
